// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
//
// Decode-to-execute pipeline register for the pipelined MIPS core, with
// load-use hazard detection and bubble insertion.
//
// The stage captures three things for EX:
//   - the control bundle from the opcode decoder,
//   - the register-file operands and PC+4,
//   - the decoded instruction fields and the extended immediate.
//
// When the instruction in EX is a load and the instruction in ID reads the
// loaded register, this stage inserts a bubble. It also raises Stall so
// that the PC and the IF/ID register hold the dependent instruction for one
// cycle. A branch flush also inserts a bubble, and it overrides the stall so
// that IF/ID advances past the squashed instruction.
//
// Parameters
//   N_BITS          datapath width (operands, immediate, PC+4)
//   STALL_CNT_BITS  width of the saturating hazard-bubble counter
//
// Ports
//   clk                 pipeline clock, rising edge
//   reset               asynchronous, active-high; clears every register
//   Instruction_ID      instruction held in IF/ID
//   PC4_ID              PC+4 of that instruction
//   ReadData1_ID/2_ID   register-file outputs for rs / rt
//   *_ID control bits   decoder control bundle, ALUOp_ID is the ALU class
//   Flush               branch taken downstream; squash the ID instruction
//   *_EX outputs        registered control bundle, operands and fields
//   Valid_EX            EX slot holds a real instruction (0 = bubble)
//   Stall               hold PC and IF/ID this cycle (combinational)
//   StallCount          hazard bubbles inserted so far, saturating
// ---------------------------------------------------------------------------
module id_ex_hazard_stage #(
  parameter int N_BITS         = 32,
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [31:0]               Instruction_ID,
  input  logic [N_BITS-1:0]         PC4_ID,
  input  logic [N_BITS-1:0]         ReadData1_ID,
  input  logic [N_BITS-1:0]         ReadData2_ID,

  input  logic                      RegDst_ID,
  input  logic                      ALUSrc_ID,
  input  logic                      MemtoReg_ID,
  input  logic                      RegWrite_ID,
  input  logic                      MemRead_ID,
  input  logic                      MemWrite_ID,
  input  logic                      BranchNE_ID,
  input  logic                      BranchEQ_ID,
  input  logic [2:0]                ALUOp_ID,

  input  logic                      Flush,

  output logic                      RegDst_EX,
  output logic                      ALUSrc_EX,
  output logic                      MemtoReg_EX,
  output logic                      RegWrite_EX,
  output logic                      MemRead_EX,
  output logic                      MemWrite_EX,
  output logic                      BranchNE_EX,
  output logic                      BranchEQ_EX,
  output logic [2:0]                ALUOp_EX,

  output logic [N_BITS-1:0]         ReadData1_EX,
  output logic [N_BITS-1:0]         ReadData2_EX,
  output logic [N_BITS-1:0]         PC4_EX,
  output logic [N_BITS-1:0]         Immediate_EX,

  output logic [4:0]                Rs_EX,
  output logic [4:0]                Rt_EX,
  output logic [4:0]                Rd_EX,

  output logic                      Valid_EX,
  output logic                      Stall,
  output logic [STALL_CNT_BITS-1:0] StallCount
);

  // ALU class that selects zero extension of the immediate (ORI).
  localparam logic [2:0] ALU_OP_ORI = 3'b101;

  // Decoded fields of the instruction sitting in ID.
  logic [4:0]        rsId;
  logic [4:0]        rtId;
  logic [4:0]        rdId;
  logic [15:0]       immId;
  logic [N_BITS-1:0] immExtId;

  logic usesRtId;
  logic rtEqualsRs;
  logic rtEqualsRt;
  logic loadInEx;
  logic hazard;
  logic insertBubble;

  // The opcode and funct bits are consumed by the decoder upstream; this
  // stage only needs the register fields and the immediate.
  logic unusedOpcode;
  assign unusedOpcode = ^Instruction_ID[31:26];

  assign rsId  = Instruction_ID[25:21];
  assign rtId  = Instruction_ID[20:16];
  assign rdId  = Instruction_ID[15:11];
  assign immId = Instruction_ID[15:0];

  // Immediate extension: ORI takes its immediate zero-extended, every other
  // class sign-extends from bit 15 (loads, stores, ADDI, branch offsets).
  always_comb begin
    immExtId = '0;
    if (ALUOp_ID == ALU_OP_ORI) begin
      immExtId = {{(N_BITS-16){1'b0}}, immId};
    end else begin
      immExtId = {{(N_BITS-16){immId[15]}}, immId};
    end
  end

  // The ID instruction reads rt as a source when it is an R-type (RegDst),
  // a store (rt is the store data) or a branch (rt is compared). For loads,
  // ADDI and ORI rt is only the destination, so a match there is harmless.
  assign usesRtId = RegDst_ID | MemWrite_ID | BranchEQ_ID | BranchNE_ID;

  // Load-use detection. A load targeting $zero never produces a value that
  // anyone can consume, so Rt_EX == 0 is excluded. Valid_EX guards against
  // stale fields left behind in a bubble slot.
  assign loadInEx   = Valid_EX & MemRead_EX & (Rt_EX != 5'd0);
  assign rtEqualsRs = (Rt_EX == rsId);
  assign rtEqualsRt = usesRtId & (Rt_EX == rtId);
  assign hazard     = loadInEx & (rtEqualsRs | rtEqualsRt);

  // A squashed instruction must never hold the front end, otherwise IF/ID
  // would keep re-presenting the instruction the branch is discarding.
  assign Stall = hazard & ~Flush;

  // Both a hazard and a flush turn the EX slot into a bubble.
  assign insertBubble = hazard | Flush;

  // Control bundle and valid bit. These are the only registers that must
  // be cleared for a bubble: with every control bit low the EX slot cannot
  // write a register, touch memory or branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegDst_EX   <= 1'b0;
      ALUSrc_EX   <= 1'b0;
      MemtoReg_EX <= 1'b0;
      RegWrite_EX <= 1'b0;
      MemRead_EX  <= 1'b0;
      MemWrite_EX <= 1'b0;
      BranchNE_EX <= 1'b0;
      BranchEQ_EX <= 1'b0;
      ALUOp_EX    <= 3'b000;
      Valid_EX    <= 1'b0;
    end else if (insertBubble) begin
      RegDst_EX   <= 1'b0;
      ALUSrc_EX   <= 1'b0;
      MemtoReg_EX <= 1'b0;
      RegWrite_EX <= 1'b0;
      MemRead_EX  <= 1'b0;
      MemWrite_EX <= 1'b0;
      BranchNE_EX <= 1'b0;
      BranchEQ_EX <= 1'b0;
      ALUOp_EX    <= 3'b000;
      Valid_EX    <= 1'b0;
    end else begin
      RegDst_EX   <= RegDst_ID;
      ALUSrc_EX   <= ALUSrc_ID;
      MemtoReg_EX <= MemtoReg_ID;
      RegWrite_EX <= RegWrite_ID;
      MemRead_EX  <= MemRead_ID;
      MemWrite_EX <= MemWrite_ID;
      BranchNE_EX <= BranchNE_ID;
      BranchEQ_EX <= BranchEQ_ID;
      ALUOp_EX    <= ALUOp_ID;
      Valid_EX    <= 1'b1;
    end
  end

  // Operands, PC+4, immediate and register fields. These load on every
  // edge, bubble or not: while Valid_EX is low nothing downstream looks at
  // them, and the hazard logic is gated by Valid_EX as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadData1_EX <= '0;
      ReadData2_EX <= '0;
      PC4_EX       <= '0;
      Immediate_EX <= '0;
      Rs_EX        <= 5'd0;
      Rt_EX        <= 5'd0;
      Rd_EX        <= 5'd0;
    end else begin
      ReadData1_EX <= ReadData1_ID;
      ReadData2_EX <= ReadData2_ID;
      PC4_EX       <= PC4_ID;
      Immediate_EX <= immExtId;
      Rs_EX        <= rsId;
      Rt_EX        <= rtId;
      Rd_EX        <= rdId;
    end
  end

  // Hazard-bubble counter. Only real stalls are counted; a flush bubble,
  // even one that coincides with a hazard, is not. The counter sticks at
  // all-ones rather than wrapping so that a long run still reads as "many".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != {STALL_CNT_BITS{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_hazard_stage
//
// Directed self-checking bench for id_ex_hazard_stage. A second instance
// with a 4-bit stall counter shares every input with the main instance so
// that counter saturation is reachable in a few dozen cycles.
// ---------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

  // Control bundle packing: {RegDst, ALUSrc, MemtoReg, RegWrite,
  //                          MemRead, MemWrite, BranchNE, BranchEQ}
  localparam logic [7:0] CTRL_RTYPE = 8'b1001_0000;
  localparam logic [7:0] CTRL_ADDI  = 8'b0101_0000;
  localparam logic [7:0] CTRL_LW    = 8'b0111_1000;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction_ID;
  logic [31:0] PC4_ID;
  logic [31:0] ReadData1_ID;
  logic [31:0] ReadData2_ID;
  logic        RegDst_ID, ALUSrc_ID, MemtoReg_ID, RegWrite_ID;
  logic        MemRead_ID, MemWrite_ID, BranchNE_ID, BranchEQ_ID;
  logic [2:0]  ALUOp_ID;
  logic        Flush;

  logic        RegDst_EX, ALUSrc_EX, MemtoReg_EX, RegWrite_EX;
  logic        MemRead_EX, MemWrite_EX, BranchNE_EX, BranchEQ_EX;
  logic [2:0]  ALUOp_EX;
  logic [31:0] ReadData1_EX, ReadData2_EX, PC4_EX, Immediate_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
  logic        Valid_EX;
  logic        Stall;
  logic [15:0] StallCount;

  logic        sRegDst, sALUSrc, sMemtoReg, sRegWrite;
  logic        sMemRead, sMemWrite, sBranchNE, sBranchEQ;
  logic [2:0]  sALUOp;
  logic [31:0] sReadData1, sReadData2, sPC4, sImmediate;
  logic [4:0]  sRs, sRt, sRd;
  logic        sValid;
  logic        sStall;
  logic [3:0]  sStallCount;

  logic [7:0]  ctrlEx;

  int checks;
  int errors;

  assign ctrlEx = {RegDst_EX, ALUSrc_EX, MemtoReg_EX, RegWrite_EX,
                   MemRead_EX, MemWrite_EX, BranchNE_EX, BranchEQ_EX};

  id_ex_hazard_stage #(.N_BITS(32), .STALL_CNT_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .Instruction_ID(Instruction_ID), .PC4_ID(PC4_ID),
    .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
    .RegDst_ID(RegDst_ID), .ALUSrc_ID(ALUSrc_ID), .MemtoReg_ID(MemtoReg_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
    .BranchNE_ID(BranchNE_ID), .BranchEQ_ID(BranchEQ_ID), .ALUOp_ID(ALUOp_ID),
    .Flush(Flush),
    .RegDst_EX(RegDst_EX), .ALUSrc_EX(ALUSrc_EX), .MemtoReg_EX(MemtoReg_EX),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .BranchNE_EX(BranchNE_EX), .BranchEQ_EX(BranchEQ_EX), .ALUOp_EX(ALUOp_EX),
    .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX),
    .PC4_EX(PC4_EX), .Immediate_EX(Immediate_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
    .Valid_EX(Valid_EX), .Stall(Stall), .StallCount(StallCount)
  );

  id_ex_hazard_stage #(.N_BITS(32), .STALL_CNT_BITS(4)) dutSmall (
    .clk(clk), .reset(reset),
    .Instruction_ID(Instruction_ID), .PC4_ID(PC4_ID),
    .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
    .RegDst_ID(RegDst_ID), .ALUSrc_ID(ALUSrc_ID), .MemtoReg_ID(MemtoReg_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
    .BranchNE_ID(BranchNE_ID), .BranchEQ_ID(BranchEQ_ID), .ALUOp_ID(ALUOp_ID),
    .Flush(Flush),
    .RegDst_EX(sRegDst), .ALUSrc_EX(sALUSrc), .MemtoReg_EX(sMemtoReg),
    .RegWrite_EX(sRegWrite), .MemRead_EX(sMemRead), .MemWrite_EX(sMemWrite),
    .BranchNE_EX(sBranchNE), .BranchEQ_EX(sBranchEQ), .ALUOp_EX(sALUOp),
    .ReadData1_EX(sReadData1), .ReadData2_EX(sReadData2),
    .PC4_EX(sPC4), .Immediate_EX(sImmediate),
    .Rs_EX(sRs), .Rt_EX(sRt), .Rd_EX(sRd),
    .Valid_EX(sValid), .Stall(sStall), .StallCount(sStallCount)
  );

  // Free-running pipeline clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and let the registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID together with its decoder bundle.
  task automatic applyStimulus(input logic [31:0] instr, input logic [7:0] ctrl,
                               input logic [2:0] aluOp, input logic flush);
    Instruction_ID = instr;
    {RegDst_ID, ALUSrc_ID, MemtoReg_ID, RegWrite_ID,
     MemRead_ID, MemWrite_ID, BranchNE_ID, BranchEQ_ID} = ctrl;
    ALUOp_ID       = aluOp;
    Flush          = flush;
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(32'h0000_0000, 8'h00, 3'b000, 1'b0);
    PC4_ID       = 32'h0000_0000;
    ReadData1_ID = 32'h0000_0000;
    ReadData2_ID = 32'h0000_0000;
    reset = 1'b1;
    #1;
    checks++;
    if (Valid_EX !== 1'b0) begin
      $display("[TB] FAIL reset_valid: got %b expected 0", Valid_EX); errors++;
    end
    checks++;
    if (StallCount !== 16'h0000) begin
      $display("[TB] FAIL reset_stallcount: got %h expected 0000", StallCount); errors++;
    end
    checks++;
    if ({ctrlEx, ALUOp_EX, Immediate_EX, Rt_EX} !== '0) begin
      $display("[TB] FAIL reset_regs: ctrl %h aluop %h imm %h rt %0d expected all 0",
               ctrlEx, ALUOp_EX, Immediate_EX, Rt_EX); errors++;
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    PC4_ID       = 32'h0040_0004;
    ReadData1_ID = 32'h1234_5678;
    applyStimulus(32'h2009_0005, CTRL_ADDI, 3'b100, 1'b0);
    tick();
    checks++;
    if (Immediate_EX !== 32'h0000_0005) begin
      $display("[TB] FAIL addi_imm_pos: got %h expected 00000005", Immediate_EX); errors++;
    end
    checks++;
    if (Rt_EX !== 5'd9 || Valid_EX !== 1'b1 || ALUOp_EX !== 3'b100) begin
      $display("[TB] FAIL addi_fields: rt %0d valid %b aluop %b expected 9 1 100",
               Rt_EX, Valid_EX, ALUOp_EX); errors++;
    end
    checks++;
    if (ctrlEx !== CTRL_ADDI || PC4_EX !== 32'h0040_0004 || ReadData1_EX !== 32'h1234_5678) begin
      $display("[TB] FAIL addi_data: ctrl %h pc4 %h rd1 %h expected 50 00400004 12345678",
               ctrlEx, PC4_EX, ReadData1_EX); errors++;
    end
    applyStimulus(32'h2009_FFFF, CTRL_ADDI, 3'b100, 1'b0);
    tick();
    checks++;
    if (Immediate_EX !== 32'hFFFF_FFFF) begin
      $display("[TB] FAIL addi_imm_neg: got %h expected ffffffff", Immediate_EX); errors++;
    end
  endtask

  task automatic test_ori();
    applyStimulus(32'h3409_8000, CTRL_ADDI, 3'b101, 1'b0);
    tick();
    checks++;
    if (Immediate_EX !== 32'h0000_8000 || ALUOp_EX !== 3'b101) begin
      $display("[TB] FAIL ori_zero_ext: imm %h aluop %b expected 00008000 101",
               Immediate_EX, ALUOp_EX); errors++;
    end
  endtask

  // lw $8,0($4) then add $10,$8,$9 (rs dependency), then add $10,$9,$8.
  task automatic test_load_use();
    applyStimulus(32'h8C88_0000, CTRL_LW, 3'b000, 1'b0);
    tick();
    applyStimulus(32'h0109_5020, CTRL_RTYPE, 3'b010, 1'b0);
    checks++;
    if (Stall !== 1'b1) begin
      $display("[TB] FAIL loaduse_stall: got %b expected 1", Stall); errors++;
    end
    tick();
    checks++;
    if (Valid_EX !== 1'b0 || ctrlEx !== 8'h00 || StallCount !== 16'd1 || Stall !== 1'b0) begin
      $display("[TB] FAIL loaduse_bubble: valid %b ctrl %h count %0d stall %b expected 0 00 1 0",
               Valid_EX, ctrlEx, StallCount, Stall); errors++;
    end
    tick();
    checks++;
    if (Valid_EX !== 1'b1 || Rs_EX !== 5'd8 || Rd_EX !== 5'd10 || ctrlEx !== CTRL_RTYPE) begin
      $display("[TB] FAIL loaduse_issue: valid %b rs %0d rd %0d ctrl %h expected 1 8 10 90",
               Valid_EX, Rs_EX, Rd_EX, ctrlEx); errors++;
    end
    applyStimulus(32'h8C88_0000, CTRL_LW, 3'b000, 1'b0);
    tick();
    applyStimulus(32'h0128_5020, CTRL_RTYPE, 3'b010, 1'b0);
    checks++;
    if (Stall !== 1'b1) begin
      $display("[TB] FAIL loaduse_rt_stall: got %b expected 1", Stall); errors++;
    end
    tick();
    tick();
    checks++;
    if (StallCount !== 16'd2 || Valid_EX !== 1'b1) begin
      $display("[TB] FAIL loaduse_rt_count: count %0d valid %b expected 2 1",
               StallCount, Valid_EX); errors++;
    end
  endtask

  // ADDI with rt matching the load target does not read rt: no bubble.
  // A load to $zero never causes a hazard either.
  task automatic test_no_hazard();
    applyStimulus(32'h8C88_0000, CTRL_LW, 3'b000, 1'b0);
    tick();
    applyStimulus(32'h2088_0001, CTRL_ADDI, 3'b100, 1'b0);
    checks++;
    if (Stall !== 1'b0) begin
      $display("[TB] FAIL addi_rt_nostall: got %b expected 0", Stall); errors++;
    end
    tick();
    checks++;
    if (Valid_EX !== 1'b1 || Rt_EX !== 5'd8 || StallCount !== 16'd2) begin
      $display("[TB] FAIL addi_rt_issue: valid %b rt %0d count %0d expected 1 8 2",
               Valid_EX, Rt_EX, StallCount); errors++;
    end
    applyStimulus(32'h8C80_0000, CTRL_LW, 3'b000, 1'b0);
    tick();
    applyStimulus(32'h0000_5020, CTRL_RTYPE, 3'b010, 1'b0);
    checks++;
    if (Stall !== 1'b0) begin
      $display("[TB] FAIL zero_reg_nostall: got %b expected 0", Stall); errors++;
    end
    tick();
  endtask

  task automatic test_flush();
    applyStimulus(32'h8C88_0000, CTRL_LW, 3'b000, 1'b0);
    tick();
    applyStimulus(32'h0109_5020, CTRL_RTYPE, 3'b010, 1'b1);
    checks++;
    if (Stall !== 1'b0) begin
      $display("[TB] FAIL flush_stall: got %b expected 0", Stall); errors++;
    end
    tick();
    checks++;
    if (Valid_EX !== 1'b0 || ctrlEx !== 8'h00 || StallCount !== 16'd2) begin
      $display("[TB] FAIL flush_bubble: valid %b ctrl %h count %0d expected 0 00 2",
               Valid_EX, ctrlEx, StallCount); errors++;
    end
    Flush = 1'b0;
  endtask

  // lw $8 ; lw $9,0($8) ; add $10,$9,$9
  task automatic test_back_to_back();
    applyStimulus(32'h8C88_0000, CTRL_LW, 3'b000, 1'b0);
    tick();
    applyStimulus(32'h8D09_0000, CTRL_LW, 3'b000, 1'b0);
    checks++;
    if (Stall !== 1'b1) begin
      $display("[TB] FAIL b2b_first_stall: got %b expected 1", Stall); errors++;
    end
    tick();
    tick();
    checks++;
    if (Valid_EX !== 1'b1 || Rt_EX !== 5'd9 || MemRead_EX !== 1'b1 || StallCount !== 16'd3) begin
      $display("[TB] FAIL b2b_second_load: valid %b rt %0d memread %b count %0d expected 1 9 1 3",
               Valid_EX, Rt_EX, MemRead_EX, StallCount); errors++;
    end
    applyStimulus(32'h0129_5020, CTRL_RTYPE, 3'b010, 1'b0);
    checks++;
    if (Stall !== 1'b1) begin
      $display("[TB] FAIL b2b_second_stall: got %b expected 1", Stall); errors++;
    end
  endtask

  // Entered while Stall is high from test_back_to_back.
  task automatic test_reset_mid_stall();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0 || Valid_EX !== 1'b0 || StallCount !== 16'd0 || Rt_EX !== 5'd0) begin
      $display("[TB] FAIL reset_async: stall %b valid %b count %0d rt %0d expected 0 0 0 0",
               Stall, Valid_EX, StallCount, Rt_EX); errors++;
    end
    tick();
    reset = 1'b0;
    applyStimulus(32'h0000_0000, 8'h00, 3'b000, 1'b0);
    tick();
  endtask

  // Twenty load/dependent-add pairs: the 4-bit counter sticks at 15 while
  // the 16-bit counter keeps counting to 20.
  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'h8C88_0000, CTRL_LW, 3'b000, 1'b0);
      tick();
      applyStimulus(32'h0109_5020, CTRL_RTYPE, 3'b010, 1'b0);
      tick();
      tick();
      if (i == 14) begin
        checks++;
        if (sStallCount !== 4'hF) begin
          $display("[TB] FAIL sat_reach: got %h expected f", sStallCount); errors++;
        end
      end
    end
    checks++;
    if (sStallCount !== 4'hF) begin
      $display("[TB] FAIL sat_hold: got %h expected f", sStallCount); errors++;
    end
    checks++;
    if (StallCount !== 16'd20) begin
      $display("[TB] FAIL sat_wide_count: got %0d expected 20", StallCount); errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    Flush  = 1'b0;
    test_reset();
    test_addi();
    test_ori();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
